// File: rtl/fpga_lut_fabric.sv
// rtl/fpga_lut_fabric.sv - 4-input LUT fabric with checksummed byte-stream configuration loader
module fpga_lut_fabric #(
  parameter int NUM_LUTS   = 16,
  parameter int NUM_INPUTS = 4,
  parameter int LUT_K      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [7:0]            cfg_data,
  input  logic                  cfg_last,
  output logic                  cfg_done,
  output logic                  cfg_error,
  input  logic [NUM_INPUTS-1:0] fpga_in,
  output logic [NUM_LUTS-1:0]   fpga_out
);

  localparam int SEL_W   = $clog2(NUM_INPUTS);
  localparam int PAYLOAD = 3 * NUM_LUTS;
  localparam int CNT_W   = $clog2(PAYLOAD + 1);
  localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(PAYLOAD);
  localparam logic [7:0]       SYNC     = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_ERROR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter;
  logic [7:0]       csum;
  logic [7:0]       shadow [PAYLOAD];
  logic [7:0]       active [PAYLOAD];
  logic [NUM_LUTS-1:0] lut_val;
  logic             xfer;

  assign cfg_ready = (state != S_CHECK);
  assign xfer      = cfg_valid && cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (xfer && cfg_data == SYNC) state_nxt = S_LOAD;
      S_LOAD: begin
        if (xfer) begin
          if (counter == CSUM_IDX) state_nxt = cfg_last ? S_CHECK : S_ERROR;
          else if (cfg_last)       state_nxt = S_ERROR;
        end
      end
      // The checksum byte is folded into csum, so a good frame leaves zero.
      S_CHECK: state_nxt = (csum == 8'h00) ? S_IDLE : S_ERROR;
      S_ERROR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      csum      <= '0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      fpga_out  <= '0;
      for (int i = 0; i < PAYLOAD; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      fpga_out <= cfg_done ? lut_val : '0;
      case (state)
        S_IDLE: begin
          if (xfer && cfg_data == SYNC) begin
            counter   <= '0;
            csum      <= '0;
            cfg_error <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            csum <= csum ^ cfg_data;
            if (counter != CSUM_IDX) begin
              shadow[counter] <= cfg_data;
              counter         <= counter + CNT_W'(1);
            end
          end
        end
        S_CHECK: begin
          if (csum == 8'h00) begin
            active   <= shadow;
            cfg_done <= 1'b1;
          end
        end
        S_ERROR: cfg_error <= 1'b1;
        default: ;
      endcase
    end
  end

  // Per LUT: bytes {truth_lo, truth_hi, selects}; each select picks one fabric input.
  for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
    logic [2**LUT_K-1:0]   truth;
    logic [LUT_K*SEL_W-1:0] sel;
    logic [LUT_K-1:0]      idx;
    assign truth = {active[3*g+1], active[3*g]};
    assign sel   = active[3*g+2];
    for (genvar k = 0; k < LUT_K; k++) begin : g_in
      assign idx[k] = fpga_in[sel[k*SEL_W +: SEL_W]];
    end
    assign lut_val[g] = truth[idx];
  end

endmodule

// File: tb/tb_fpga_lut_fabric.sv
// tb/tb_fpga_lut_fabric.sv - randomized self-checking bench for fpga_lut_fabric
module tb_fpga_lut_fabric;

  localparam int NL = 16;
  localparam int NI = 4;
  localparam int PL = 3 * NL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [7:0]    cfg_data = 8'h00;
  logic          cfg_last = 1'b0;
  logic          cfg_done;
  logic          cfg_error;
  logic [NI-1:0] fpga_in = '0;
  logic [NL-1:0] fpga_out;

  always #5 clk = ~clk;

  fpga_lut_fabric #(.NUM_LUTS(NL), .NUM_INPUTS(NI), .LUT_K(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .cfg_done(cfg_done), .cfg_error(cfg_error),
    .fpga_in(fpga_in), .fpga_out(fpga_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: active config as truth tables plus input-select lists.
  logic [15:0] m_truth [NL];
  int          m_sel   [NL][4];
  bit          m_done = 0;
  logic [15:0] p_truth [NL];
  int          p_sel   [NL][4];
  int          pend_cyc = -1;
  int          cyc = 0;

  function automatic logic [NL-1:0] model_eval(input logic [NI-1:0] in);
    logic [NL-1:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (in[m_sel[i][k]]) idx |= (1 << k);
      r[i] = m_truth[i][idx];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [NL-1:0] e;
    cyc++;
    if (!rst) begin
      e = m_done ? model_eval(fpga_in) : '0;
      if (cyc == pend_cyc) begin
        m_truth  = p_truth;
        m_sel    = p_sel;
        m_done   = 1;
        pend_cyc = -1;
      end
      #1;
      chk("fpga_out", fpga_out, e);
      chk("cfg_done", cfg_done, m_done);
    end
  end

  bit rand_in = 0;
  always @(negedge clk) if (rand_in) fpga_in = NI'($urandom);

  int ready_low = 0;
  int xfers = 0;
  always @(negedge clk) begin
    #2;
    if (!rst && !cfg_ready) ready_low++;
    if (!rst && cfg_valid && cfg_ready) xfers++;
  end

  logic [15:0] cfg_t [NL];
  int          cfg_s [NL][4];
  logic [7:0]  frame [$];

  task automatic build_frame();
    logic [7:0] x, b;
    frame.delete();
    frame.push_back(8'hA5);
    x = 8'h00;
    for (int i = 0; i < NL; i++) begin
      b = 8'h00;
      for (int k = 0; k < 4; k++) b[2*k +: 2] = cfg_s[i][k][1:0];
      frame.push_back(cfg_t[i][7:0]);
      frame.push_back(cfg_t[i][15:8]);
      frame.push_back(b);
      x = x ^ cfg_t[i][7:0] ^ cfg_t[i][15:8] ^ b;
    end
    frame.push_back(x);
  endtask

  task automatic random_cfg();
    for (int i = 0; i < NL; i++) begin
      cfg_t[i] = 16'($urandom);
      for (int k = 0; k < 4; k++) cfg_s[i][k] = $urandom_range(0, 3);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, output int acc_cyc);
    int w;
    w = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    while (!cfg_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cfg_ready) chk("ready_timeout", 0, 1);
    acc_cyc = cyc + 1;
  endtask

  task automatic send_frame(input bit keep_valid);
    logic [7:0] x;
    bit good;
    int a;
    x = 8'h00;
    for (int i = 1; i <= PL; i++) x ^= frame[i];
    good = (frame.size() == PL + 2) && (frame[0] == 8'hA5) && (x == frame[PL+1]);
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], i == frame.size() - 1, a);
      if (i == PL + 1 && good) begin
        for (int l = 0; l < NL; l++) begin
          p_truth[l] = {frame[3*l+2], frame[3*l+1]};
          for (int k = 0; k < 4; k++) p_sel[l][k] = int'(frame[3*l+3][2*k +: 2]);
        end
        pend_cyc = a + 1;
      end
    end
    if (!keep_valid) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    m_done    = 0;
    pend_cyc  = -1;
    #1;
    chk("rst_fpga_out", fpga_out, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_cfg_error", cfg_error, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bit corrupt;
    logic [7:0] junk;
    logic [3:0] vec [4];
    bit exp0 [4];

    // Reset
    repeat (2) @(negedge clk);
    chk("reset_fpga_out", fpga_out, 0);
    chk("reset_cfg_done", cfg_done, 0);
    chk("reset_cfg_error", cfg_error, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cfg_ready", cfg_ready, 1);
    rand_in = 1;
    wait_cycles(10);

    // Single-LUT configuration
    for (int i = 0; i < NL; i++) begin
      cfg_t[i] = 16'h0000;
      for (int k = 0; k < 4; k++) cfg_s[i][k] = 0;
    end
    cfg_t[0] = 16'hE9CC;
    cfg_s[0][0] = 0; cfg_s[0][1] = 3; cfg_s[0][2] = 2; cfg_s[0][3] = 1;
    build_frame();
    send_frame(0);
    wait_cycles(3);
    chk("single_done", cfg_done, 1);
    chk("single_error", cfg_error, 0);
    rand_in = 0;
    vec[0] = 4'b0000; exp0[0] = 0;
    vec[1] = 4'b0001; exp0[1] = 0;
    vec[2] = 4'b1000; exp0[2] = 1;
    vec[3] = 4'b1111; exp0[3] = 1;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      fpga_in = vec[v];
      @(posedge clk);
      #2;
      chk($sformatf("lut0_in_%b", vec[v]), fpga_out[0], exp0[v]);
    end
    rand_in = 1;

    // Bad checksum keeps the prior config
    frame[PL+1] = 8'h48;
    send_frame(0);
    wait_cycles(4);
    chk("badcsum_error", cfg_error, 1);
    chk("badcsum_done", cfg_done, 1);
    wait_cycles(5);

    // Early last on byte 20, junk, then a valid frame
    random_cfg();
    build_frame();
    for (int i = 0; i <= 20; i++) send_byte(frame[i], i == 20, a);
    @(posedge clk);
    #2;
    chk("early_err_e0", cfg_error, 0);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    @(posedge clk);
    #2;
    chk("early_err_e1", cfg_error, 1);
    for (int j = 0; j < 6; j++) begin
      junk = 8'($urandom);
      if (junk == 8'hA5) junk = 8'h5A;
      send_byte(junk, j == 2, a);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    wait_cycles(3);
    chk("junk_error_held", cfg_error, 1);
    send_frame(0);
    wait_cycles(3);
    chk("recover_error", cfg_error, 0);
    chk("recover_done", cfg_done, 1);

    // Back-to-back frames with cfg_valid held high across CHECK
    wait_cycles(2);
    ready_low = 0;
    xfers     = 0;
    random_cfg();
    build_frame();
    send_frame(1);
    random_cfg();
    build_frame();
    send_frame(0);
    wait_cycles(4);
    chk("b2b_ready_low", ready_low, 2);
    chk("b2b_xfers", xfers, 2 * (PL + 2));
    chk("b2b_error", cfg_error, 0);

    // Reset in the middle of a second frame
    random_cfg();
    build_frame();
    for (int i = 0; i < 30; i++) send_byte(frame[i], 1'b0, a);
    do_reset();
    wait_cycles(5);
    chk("midrst_done", cfg_done, 0);
    chk("midrst_out", fpga_out, 0);

    // Randomized configurations, some with corrupted checksums
    for (int f = 0; f < 6; f++) begin
      random_cfg();
      build_frame();
      corrupt = (f % 3 == 2);
      if (corrupt) frame[PL+1] = frame[PL+1] ^ 8'(1 << $urandom_range(0, 7));
      send_frame(0);
      wait_cycles(20);
      chk($sformatf("rand%0d_error", f), cfg_error, corrupt);
    end

    rand_in = 0;
    wait_cycles(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpga_lut_fabric.md
# fpga_lut_fabric

- Programmable 4-input-LUT fabric and its serial configuration loader.
- It is the hardware that a generated `fpga_design` bitstream programs; each generated design is the golden model for this block.
- A byte-stream configuration port loads, per LUT, a truth table and input-select fields, validates a checksum and commits them atomically.
- The fabric then evaluates `fpga_in` into registered `fpga_out`.

## Interface
Parameters:
- NUM_LUTS, 16, number of LUTs, equal to the `fpga_out` width
- NUM_INPUTS, 4, number of fabric inputs
- LUT_K, 4, LUT input count; fixed at 4 for the byte layout below; SEL_W = 2 = clog2(NUM_INPUTS)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config byte valid
- cfg_ready  out  1  loader can accept a byte; transfer occurs on clk when valid&&ready
- cfg_data  in  8  config byte
- cfg_last  in  1  marks final byte of a frame
- cfg_done  out  1  active configuration is valid
- cfg_error  out  1  last frame rejected; sticky
- fpga_in  in  NUM_INPUTS  fabric inputs
- fpga_out  out  NUM_LUTS  registered LUT outputs

## Operation
- **Frame:** 1 sync byte 0xA5, then 3 bytes per LUT (LUT0 first; 48 bytes at defaults), then 1 checksum byte. 50 bytes total; cfg_last is asserted on the checksum byte only.
- **Per-LUT bytes:**
  - b0 = truth[7:0]
  - b1 = truth[15:8]
  - b2 = {sel3,sel2,sel1,sel0}, with sel0 in bits[1:0]
- **LUT evaluation:** lut_in_k = fpga_in[sel_k]. Output = truth[{lut_in3,lut_in2,lut_in1,lut_in0}].
- **Checksum:** XOR of all 48 payload bytes. The sync byte is excluded.
- **Shadow/active:** payload is written to shadow registers. Active registers change only on commit, so fabric outputs keep using the old config throughout a load.
- **FSM states:**
  - IDLE: cfg_ready=1. A byte == 0xA5 goes to LOAD, clears the byte counter and checksum, and clears cfg_error. Any other byte is discarded, state unchanged.
  - LOAD: cfg_ready=1. Each accepted byte goes to shadow[counter], counter++ and is XORed into the checksum.
    - Payload byte with cfg_last=1 → ERROR (early last).
    - Checksum byte (counter==48) with cfg_last=0 → ERROR (missing last).
    - Checksum byte with cfg_last=1 → CHECK.
  - CHECK: cfg_ready=0, lasts 1 cycle.
    - Match → active<=shadow, cfg_done<=1, → IDLE.
    - Mismatch → ERROR.
  - ERROR: cfg_error<=1, → IDLE next cycle. The active config and cfg_done are untouched.
- **Counter:** 6 bits, never wraps past 48. Any byte beyond this point is a protocol error, handled as above.
- **fpga_out:** registered every cycle as the evaluation using the active config. Held at 0 while cfg_done=0.

## Timing
- **Reset (async assert):**
  - State IDLE; counter and checksum 0; shadow and active cleared to 0.
  - cfg_done=0, cfg_error=0, fpga_out=0, cfg_ready=1 (after the first clock edge in IDLE; combinational from state).
- **Reset mid-load:** the frame is abandoned, all of the above applies, and a prior active config is lost.
- **Output latency:** fpga_out updates 1 cycle after fpga_in (1 register stage).
- **Commit timing:** checksum byte accepted at edge E0 → CHECK during the following cycle → edge E1 commits and sets cfg_done. Edge E2 is the first fpga_out update using the new config.
- **Error timing:** on error, cfg_error rises 2 edges after the offending byte (LOAD→ERROR, then ERROR sets it).
- **cfg_ready:** low only in the CHECK cycle. cfg_valid may stay high across it; no byte is lost or duplicated.
- **cfg_error persistence:** stays 1 until the next accepted 0xA5 sync byte, or reset.

## Test plan
- **Reset:** reset → fpga_out=0, cfg_done=0, cfg_error=0, cfg_ready=1; random fpga_in → fpga_out remains 0.
- **Single-LUT config:**
  - Stimulus: load a frame with LUT0 b0=0xCC, b1=0xE9, b2=0x6C and all other LUTs 0x00, with correct checksum 0xCC^0xE9^0x6C=0x49.
  - Response: cfg_done=1 at E1.
  - fpga_in=0000 → fpga_out[0]=0.
  - fpga_in=0001 → fpga_out[0]=0.
  - fpga_in=1000 → fpga_out[0]=1.
  - fpga_in=1111 → fpga_out[0]=1.
- **Bad checksum:** the same frame with checksum 0x48 → cfg_error=1, cfg_done unchanged, fpga_out still uses the prior config.
- **Early last:** cfg_last set on byte 20 → ERROR. The next bytes are discarded until 0xA5; then a valid frame commits and clears cfg_error.
- **Backpressure and glitch-free reload:**
  - Hold cfg_valid=1 continuously across CHECK → exactly 50 bytes consumed, cfg_ready low for 1 cycle.
  - Reload a different config while toggling fpga_in → outputs match the old config until E2, the new one after.
- **Reset mid-load:** assert rst at byte 30 of a second frame → all outputs 0, cfg_done=0.
- **Full randomized config:** random 16-LUT config → every cycle fpga_out matches a reference model (evaluation of the generated 16-LUT design).
